// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one right barrel shifter (SRL/SLL/SRA) between two requesters
module shift_arbiter #(
  parameter int N = 64,
  localparam int K = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [K-1:0] req0_amt,
  input  logic [N-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [K-1:0] req1_amt,
  input  logic [N-1:0] req1_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err
);
  logic         last_grant, gnt, slot_free, xfer;
  logic [1:0]   op;
  logic [K-1:0] amt;
  logic [N-1:0] data, drev, sin, sh, srev, fill, res;
  always_comb begin
    slot_free  = !rsp_valid || rsp_ready;
    gnt        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = rst_n && slot_free && req0_valid && !gnt;
    req1_ready = rst_n && slot_free && req1_valid && gnt;
    xfer       = req0_ready || req1_ready;
    op         = gnt ? req1_op : req0_op;
    amt        = gnt ? req1_amt : req0_amt;
    data       = gnt ? req1_data : req0_data;
    sin        = (op == 2'b01) ? drev : data;
    sh         = sin >> amt;
    fill       = (op == 2'b10 && data[N-1]) ? ~({N{1'b1}} >> amt) : '0;
    res        = (op == 2'b11) ? data : (op == 2'b01) ? srev : (sh | fill);
  end
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign drev[i] = data[N-1-i];
    assign srev[i] = sh[N-1-i];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      rsp_valid  <= 1'b1;
      rsp_data   <= res;
      rsp_id     <= gnt;
      rsp_err    <= (op == 2'b11);
      last_grant <= gnt;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end
endmodule
